// File: rtl/letter_pkg.sv
// Shared constants, playback state encoding and the ASCII -> tilt/switch code mapping
// for the tilt-entry letter buffer.
package letter_pkg;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef struct packed {
        logic       legal;
        logic       empty;
        logic [1:0] tilt;
        logic [2:0] sw;
    } code_t;

    // index = ascii - 'A'; tilt carries index[4:3], switch carries index[2:0]
    function automatic code_t to_code(input logic [7:0] ascii);
        code_t      c;
        logic [4:0] idx;
        idx     = 5'(ascii - ASCII_A);
        c.legal = (ascii >= ASCII_A) && (ascii <= ASCII_Z);
        c.empty = (ascii == ASCII_NUL) || (ascii == ASCII_SPACE);
        c.tilt  = c.legal ? idx[4:3] : 2'd0;
        c.sw    = c.legal ? idx[2:0] : 3'd0;
        return c;
    endfunction

endpackage

// File: rtl/letter_encoder.sv
// Combinational ASCII -> legal/empty/tilt/switch encoder; codes are zero for
// anything outside A..Z.
module letter_encoder
    import letter_pkg::*;
(
    input  logic [7:0] ascii_i,
    output logic       legal_o,
    output logic       empty_o,
    output logic [1:0] tilt_o,
    output logic [2:0] sw_o
);

    code_t code;

    assign code    = to_code(ascii_i);
    assign legal_o = code.legal;
    assign empty_o = code.empty;
    assign tilt_o  = code.tilt;
    assign sw_o    = code.sw;

endmodule

// File: rtl/letter_player.sv
// Snapshots three ASCII slots on start and plays them back left to right as tilt/switch
// codes with a hold/gap dwell. Optional LETTER_PLAYER_LOOP_EN gives continuous replay.
module letter_player
    import letter_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 10_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] letter1,
    input  logic [7:0] letter2,
    input  logic [7:0] letter3,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] tilt_code,
    output logic [2:0] switch_code,
    output logic [7:0] letter_out,
    output logic [1:0] slot,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       bad_char,
    output logic [2:0] dbg_state
);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_dwell
        $error("letter_player: HOLD_CYCLES and GAP_CYCLES must be at least 1");
    end
    if (longint'(HOLD_CYCLES) > (longint'(1) << CNT_W) ||
        longint'(GAP_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("letter_player: CNT_W too narrow for HOLD_CYCLES/GAP_CYCLES");
    end

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       snap1_q, snap1_d, snap2_q, snap2_d, snap3_q, snap3_d;
    logic             bad_q, bad_d;

    logic [1:0] tilt_q, tilt_d;
    logic [2:0] sw_q, sw_d;
    logic [7:0] letter_q, letter_d;
    logic [1:0] slot_q, slot_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] cur_ascii;
    logic       cur_legal, cur_empty;
    logic [1:0] cur_tilt;
    logic [2:0] cur_sw;

    always_comb begin
        cur_ascii = 8'h00;
        case (ptr_q)
            2'd1:    cur_ascii = snap1_q;
            2'd2:    cur_ascii = snap2_q;
            2'd3:    cur_ascii = snap3_q;
            default: cur_ascii = 8'h00;
        endcase
    end

    letter_encoder u_enc (
        .ascii_i (cur_ascii),
        .legal_o (cur_legal),
        .empty_o (cur_empty),
        .tilt_o  (cur_tilt),
        .sw_o    (cur_sw)
    );

`ifdef LETTER_PLAYER_LOOP_EN
    logic any_legal;
    assign any_legal = to_code(snap1_q).legal | to_code(snap2_q).legal |
                       to_code(snap3_q).legal;
`endif

    // Advancing past slot 3 (by skip or by end of gap) goes straight to DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        snap1_d = snap1_q;
        snap2_d = snap2_q;
        snap3_d = snap3_q;
        bad_d   = bad_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        snap1_d = letter1;
                        snap2_d = letter2;
                        snap3_d = letter3;
                        bad_d   = 1'b0;
                        ptr_d   = 2'd1;
                    end
                end
                LOAD: begin
                    if (cur_legal) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        if (!cur_empty) bad_d = 1'b1;
                        if (ptr_q == 2'd3) state_d = DONE;
                        else ptr_d = ptr_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        if (ptr_q == 2'd3) begin
                            state_d = DONE;
                        end else begin
                            state_d = LOAD;
                            ptr_d   = ptr_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
`ifdef LETTER_PLAYER_LOOP_EN
                    if (any_legal) begin
                        state_d = LOAD;
                        ptr_d   = 2'd1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        valid_d  = (state_d == HOLD);
        tilt_d   = valid_d ? cur_tilt  : 2'd0;
        sw_d     = valid_d ? cur_sw    : 3'd0;
        letter_d = valid_d ? cur_ascii : 8'h00;
        slot_d   = valid_d ? ptr_q     : 2'd0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
            snap1_q  <= 8'h00;
            snap2_q  <= 8'h00;
            snap3_q  <= 8'h00;
            bad_q    <= 1'b0;
            tilt_q   <= 2'd0;
            sw_q     <= 3'd0;
            letter_q <= 8'h00;
            slot_q   <= 2'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            snap1_q  <= snap1_d;
            snap2_q  <= snap2_d;
            snap3_q  <= snap3_d;
            bad_q    <= bad_d;
            tilt_q   <= tilt_d;
            sw_q     <= sw_d;
            letter_q <= letter_d;
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tilt_code   = tilt_q;
    assign switch_code = sw_q;
    assign letter_out  = letter_q;
    assign slot        = slot_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bad_char    = bad_q;
    assign dbg_state   = state_q;

endmodule
